// File: rtl/wb_cmd_bridge_pkg.sv
// rtl/wb_cmd_bridge_pkg.sv - shared state encoding and command word layout for the host-to-Wishbone bridge
package wb_cmd_bridge_pkg;

  localparam int WB_ADR_W = 5;

  // Host command word bit positions
  localparam int WE_BIT  = 31;
  localparam int ADR_MSB = 28;
  localparam int ADR_LSB = 24;
  localparam int DAT_MSB = 15;
  localparam int DAT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Write payload is the 16-bit command data zero-extended to the bus width
  function automatic logic [31:0] wr_word(input logic [DAT_MSB-DAT_LSB:0] d);
    return {16'h0000, d};
  endfunction

endpackage

// File: rtl/wb_cmd_bridge_if.sv
// rtl/wb_cmd_bridge_if.sv - Wishbone classic bus bundle between the bridge and the SPI master
interface wb_cmd_bridge_if;
  import wb_cmd_bridge_pkg::*;

  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [WB_ADR_W-1:0] wb_adr_o;
  logic [3:0]          wb_sel_o;
  logic [31:0]         wb_dat_o;
  logic [31:0]         wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/wb_cmd_bridge.sv
// rtl/wb_cmd_bridge.sv - turns a triggered host command word into one Wishbone classic read or write
module wb_cmd_bridge
  import wb_cmd_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ep_dataout,
  input  logic                trigger,
  wb_cmd_bridge_if.master     wb,
  output logic                busy,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic                error,
  output logic                overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                overrun_q, overrun_d;

  // Reserved command bits are deliberately ignored
  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, ep_dataout[30:29], ep_dataout[23:16]};

  // Next-state and next-output logic; done/rd_valid default low so they pulse for the RESP cycle only
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    error_d    = error_q;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_BUS;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          we_d    = ep_dataout[WE_BIT];
          adr_d   = ep_dataout[ADR_MSB:ADR_LSB];
          dat_d   = ep_dataout[WE_BIT] ? wr_word(ep_dataout[DAT_MSB:DAT_LSB]) : 32'h0;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end

      ST_BUS: begin
        if (trigger) overrun_d = 1'b1;
        // err is checked first so it wins over a coincident ack
        if (wb.wb_err_i || (!wb.wb_ack_i && cnt_q == CNT_LAST)) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else if (wb.wb_ack_i) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rd_data_d  = wb.wb_dat_i;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (trigger) overrun_d = 1'b1;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything and aborts any bus cycle at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_dat_o = dat_q;

  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign error    = error_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// tb/tb_wb_cmd_bridge.sv - scoreboard bench for wb_cmd_bridge
module tb_wb_cmd_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] ep_dataout;
  logic        trigger;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        error;
  logic        overrun;

  wb_cmd_bridge_if wbif ();

  wb_cmd_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ep_dataout (ep_dataout),
    .trigger    (trigger),
    .wb         (wbif),
    .busy       (busy),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .error      (error),
    .overrun    (overrun)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic rv, input logic [31:0] rd, input logic er);
    exp_t e;
    e.rv = rv;
    e.rd = rd;
    e.er = er;
    exp_q.push_back(e);
  endtask

  // Present a command for one edge; returns in the first BUS cycle
  task automatic issue(input logic [31:0] cmd);
    ep_dataout = cmd;
    trigger    = 1'b1;
    step();
    trigger    = 1'b0;
  endtask

  // Drive a slave response for one edge; call from a negedge
  task automatic respond(input logic [31:0] d, input logic a, input logic e);
    wbif.wb_dat_i = d;
    wbif.wb_ack_i = a;
    wbif.wb_err_i = e;
    step();
    wbif.wb_ack_i = 1'b0;
    wbif.wb_err_i = 1'b0;
  endtask

  // Response monitor: every done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rd_valid", 32'(rd_valid), 32'(mon_e.rv));
        chk("resp_rd_data", rd_data, mon_e.rd);
        chk("resp_error", 32'(error), 32'(mon_e.er));
      end
    end else if (!rst && rd_valid) begin
      chk("rd_valid_without_done", 32'(rd_valid), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    trigger       = 1'b1;
    ep_dataout    = 32'h8300_00A5;
    wbif.wb_dat_i = 32'h0;
    wbif.wb_ack_i = 1'b0;
    wbif.wb_err_i = 1'b0;

    // Reset state, with trigger held high throughout reset
    step();
    sample();
    chk("rst_cyc", 32'(wbif.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(wbif.wb_stb_o), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(wbif.wb_sel_o), 32'hF);
    chk("rst_adr", 32'(wbif.wb_adr_o), 32'h0);
    chk("rst_dat", wbif.wb_dat_o, 32'h0);
    chk("rst_flags", {28'h0, done, error, overrun, rd_valid}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    step();
    trigger = 1'b0;
    rst     = 1'b0;
    sample();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Write, ack in the third BUS cycle
    step();
    issue(32'h8300_00A5);
    push(1'b0, 32'h0, 1'b0);
    sample();
    chk("wr_cyc_stb", {30'h0, wbif.wb_cyc_o, wbif.wb_stb_o}, 32'h3);
    chk("wr_we", 32'(wbif.wb_we_o), 32'h1);
    chk("wr_adr", 32'(wbif.wb_adr_o), 32'h03);
    chk("wr_dat", wbif.wb_dat_o, 32'h0000_00A5);
    chk("wr_busy", 32'(busy), 32'h1);
    step();
    sample();
    chk("wr_hold_adr", 32'(wbif.wb_adr_o), 32'h03);
    step();
    sample();
    chk("wr_hold_cyc", 32'(wbif.wb_cyc_o), 32'h1);
    respond(32'h0, 1'b1, 1'b0);
    sample();
    chk("wr_resp_cyc", 32'(wbif.wb_cyc_o), 32'h0);
    chk("wr_resp_busy", 32'(busy), 32'h1);
    step();
    sample();
    chk("wr_idle_busy", 32'(busy), 32'h0);

    // Read with ack
    issue(32'h0000_0000);
    push(1'b1, 32'h0000_1234, 1'b0);
    sample();
    chk("rd_we", 32'(wbif.wb_we_o), 32'h0);
    chk("rd_dat_o", wbif.wb_dat_o, 32'h0);
    respond(32'h0000_1234, 1'b1, 1'b0);
    sample();
    chk("rd_data", rd_data, 32'h0000_1234);
    step();
    sample();
    chk("rd_idle_busy", 32'(busy), 32'h0);
    chk("rd_idle_valid", 32'(rd_valid), 32'h0);

    // Timeout after 8 BUS cycles
    issue(32'h1F00_0000);
    push(1'b0, 32'h0000_1234, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      sample();
      chk($sformatf("to_cyc_%0d", i), 32'(wbif.wb_cyc_o), 32'h1);
      if (i < 8) step();
    end
    step();
    sample();
    chk("to_resp_cyc", 32'(wbif.wb_cyc_o), 32'h0);
    chk("to_resp_error", 32'(error), 32'h1);
    respond(32'hDEAD_BEEF, 1'b1, 1'b0);
    sample();
    chk("to_ack_in_resp_rd_data", rd_data, 32'h0000_1234);
    chk("to_idle_busy", 32'(busy), 32'h0);
    chk("to_error_held", 32'(error), 32'h1);
    respond(32'hDEAD_BEEF, 1'b1, 1'b1);
    sample();
    chk("idle_ack_cyc", 32'(wbif.wb_cyc_o), 32'h0);
    chk("idle_ack_busy", 32'(busy), 32'h0);

    // Overrun: second trigger during BUS is dropped
    issue(32'hE2FF_BEEF);
    push(1'b0, 32'h0000_1234, 1'b0);
    sample();
    chk("ov_error_cleared", 32'(error), 32'h0);
    chk("ov_adr", 32'(wbif.wb_adr_o), 32'h02);
    chk("ov_dat", wbif.wb_dat_o, 32'h0000_BEEF);
    chk("ov_before", 32'(overrun), 32'h0);
    ep_dataout = 32'h0100_0001;
    trigger    = 1'b1;
    step();
    trigger    = 1'b0;
    sample();
    chk("ov_set", 32'(overrun), 32'h1);
    chk("ov_adr_kept", 32'(wbif.wb_adr_o), 32'h02);
    chk("ov_dat_kept", wbif.wb_dat_o, 32'h0000_BEEF);
    chk("ov_we_kept", 32'(wbif.wb_we_o), 32'h1);
    respond(32'h0, 1'b1, 1'b0);
    sample();
    step();
    issue(32'h0500_0000);
    push(1'b1, 32'h5555_AAAA, 1'b0);
    sample();
    chk("ov_next_busy", 32'(busy), 32'h1);
    chk("ov_next_adr", 32'(wbif.wb_adr_o), 32'h05);
    respond(32'h5555_AAAA, 1'b1, 1'b0);
    sample();
    step();
    sample();
    chk("ov_sticky", 32'(overrun), 32'h1);

    // Ack and err together on a read: err wins
    issue(32'h0A00_0000);
    push(1'b0, 32'h5555_AAAA, 1'b1);
    sample();
    respond(32'h0000_0099, 1'b1, 1'b1);
    sample();
    chk("ae_error", 32'(error), 32'h1);
    step();
    issue(32'h8000_0001);
    push(1'b0, 32'h5555_AAAA, 1'b0);
    sample();
    chk("ae_error_cleared", 32'(error), 32'h0);
    chk("ae_next_dat", wbif.wb_dat_o, 32'h0000_0001);
    respond(32'h0, 1'b1, 1'b0);
    sample();
    step();

    // Reset in the middle of a bus cycle
    issue(32'h0300_0000);
    sample();
    chk("mr_cyc_before", 32'(wbif.wb_cyc_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_cyc_stb", {30'h0, wbif.wb_cyc_o, wbif.wb_stb_o}, 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_overrun", 32'(overrun), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    chk("mr_rd_data", rd_data, 32'h0);
    step();
    rst = 1'b0;
    sample();
    chk("mr_after_busy", 32'(busy), 32'h0);
    repeat (4) step();
    sample();
    chk("mr_after_cyc", 32'(wbif.wb_cyc_o), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
